fetch_stage: RTL

- Instruction-fetch front end that consumes the hazard controls (stall_f, stall_d, flush_d) and the branch/jump redirect.
- Owns the PC and a valid/ready instruction-memory interface with one outstanding request.
- Owns the IF/ID pipeline register that feeds the decode stage and the hazard unit's if_id_instr input.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/if_id_reg.sv | 41 ++++
 rtl/fetch_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end (fetch_stage, if_id_reg).
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a NOP bubble.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_reset,
  input  logic   i_flush,
  input  logic   i_stall,
  input  logic   i_load_valid,
  input  if_id_t i_load,
  output if_id_t o_if_id
);

  if_id_t if_id_d, if_id_q;

  // next IF/ID contents by priority
  always_comb begin
    if_id_d = if_id_q;
    if (i_flush) begin
      if_id_d = IF_ID_BUBBLE;
    end else if (i_stall) begin
      if_id_d = if_id_q;
    end else if (i_load_valid) begin
      if_id_d = i_load;
    end else begin
      if_id_d = IF_ID_BUBBLE;
    end
  end

  // IF/ID state register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      if_id_q <= IF_ID_BUBBLE;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign o_if_id = if_id_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: PC, one-outstanding imem request FSM, 1-entry response buffer, IF/ID.
// Optional perf counters are enabled with the FETCH_PERF_EN macro.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_stall_f,
  input  logic              i_stall_d,
  input  logic              i_flush_d,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_imem_req_valid,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_req_ready,
  input  logic              i_imem_rsp_valid,
  input  logic [31:0]       i_imem_rsp_data,
  output logic [31:0]       o_if_id_instr,
  output logic [ADDR_W-1:0] o_if_id_pc,
  output logic [ADDR_W-1:0] o_if_id_pc_plus4,
  output logic              o_if_id_valid,
  output logic              o_fetch_misalign
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       o_perf_fetched,
  output logic [31:0]       o_perf_stall_cycles
`endif
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(32'd4);

  fetch_state_t      state_d, state_q;
  logic [ADDR_W-1:0] pc_d, pc_q, req_pc_d, req_pc_q, buf_pc_d, buf_pc_q;
  logic [ADDR_W-1:0] redirect_pc_s, avail_pc_s, avail_pc4_s;
  logic [31:0]       buf_instr_d, buf_instr_q, avail_instr_s;
  logic              req_valid_d, req_valid_q, drop_d, drop_q, misalign_d, misalign_q;
  logic              handshake_s, avail_s;
  if_id_t            load_s, if_id_s;

  assign redirect_pc_s = {i_redirect_pc[ADDR_W-1:2], 2'b00};
  assign handshake_s   = req_valid_q & i_imem_req_ready;
  assign misalign_d    = i_redirect_valid & (i_redirect_pc[1:0] != 2'b00);

  // fetch FSM next-state, PC, request and buffer logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    req_valid_d   = req_valid_q;
    drop_d        = drop_q;
    buf_instr_d   = buf_instr_q;
    buf_pc_d      = buf_pc_q;
    avail_s       = 1'b0;
    avail_instr_s = NOP_INSTR;
    avail_pc_s    = req_pc_q;
    case (state_q)
      S_REQ: begin
        if (handshake_s) begin
          req_pc_d    = pc_q;
          pc_d        = pc_q + PC_STEP;
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end else if (req_valid_q) begin
          req_valid_d = 1'b1;
        end else begin
          req_valid_d = !i_stall_f;
        end
        if (i_redirect_valid) begin
          pc_d = redirect_pc_s;
          // a request accepted alongside the redirect is wrong-path: drop its response
          if (handshake_s) begin
            drop_d = 1'b1;
          end else begin
            req_valid_d = !i_stall_f;
          end
        end else begin
          drop_d = drop_q;
        end
      end
      S_WAIT: begin
        if (i_imem_rsp_valid) begin
          if (drop_q || i_redirect_valid) begin
            drop_d      = 1'b0;
            state_d     = S_REQ;
            req_valid_d = !i_stall_f;
          end else if (!i_stall_d) begin
            avail_s       = 1'b1;
            avail_instr_s = i_imem_rsp_data;
            avail_pc_s    = req_pc_q;
            state_d       = S_REQ;
            req_valid_d   = !i_stall_f;
          end else begin
            buf_instr_d = i_imem_rsp_data;
            buf_pc_d    = req_pc_q;
            state_d     = S_HOLD;
          end
        end else begin
          drop_d = drop_q | i_redirect_valid;
        end
        if (i_redirect_valid) begin
          pc_d = redirect_pc_s;
        end else begin
          pc_d = pc_q;
        end
      end
      S_HOLD: begin
        if (i_redirect_valid) begin
          pc_d        = redirect_pc_s;
          state_d     = S_REQ;
          req_valid_d = !i_stall_f;
        end else if (!i_stall_d) begin
          avail_s       = 1'b1;
          avail_instr_s = buf_instr_q;
          avail_pc_s    = buf_pc_q;
          state_d       = S_REQ;
          req_valid_d   = !i_stall_f;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d     = S_REQ;
        req_valid_d = 1'b0;
        drop_d      = 1'b0;
      end
    endcase
  end

  // fetch state registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      req_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= {ADDR_W{1'b0}};
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      req_valid_q <= req_valid_d;
      drop_q      <= drop_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      misalign_q  <= misalign_d;
    end
  end

  assign avail_pc4_s = avail_pc_s + PC_STEP;
  assign load_s = '{instr: avail_instr_s, pc: 32'(avail_pc_s), pc_plus4: 32'(avail_pc4_s), valid: 1'b1};

  if_id_reg u_if_id_reg (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_flush      (i_flush_d),
    .i_stall      (i_stall_d),
    .i_load_valid (avail_s),
    .i_load       (load_s),
    .o_if_id      (if_id_s)
  );

  assign o_imem_req_valid = req_valid_q;
  assign o_imem_addr      = pc_q;
  assign o_fetch_misalign = misalign_q;
  assign o_if_id_instr    = if_id_s.instr;
  assign o_if_id_pc       = if_id_s.pc[ADDR_W-1:0];
  assign o_if_id_pc_plus4 = if_id_s.pc_plus4[ADDR_W-1:0];
  assign o_if_id_valid    = if_id_s.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_d, perf_fetched_q, perf_stall_d, perf_stall_q;
  logic        load_fire_s;

  assign load_fire_s = avail_s & ~i_flush_d & ~i_stall_d;

  // saturating event counters
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (load_fire_s && (perf_fetched_q != 32'hFFFF_FFFF)) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end else begin
      perf_fetched_d = perf_fetched_q;
    end
    if (i_stall_f && (perf_stall_q != 32'hFFFF_FFFF)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end else begin
      perf_stall_d = perf_stall_q;
    end
  end

  // perf counter registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign o_perf_fetched      = perf_fetched_q;
  assign o_perf_stall_cycles = perf_stall_q;
`endif

endmodule
